column_output_queue: RTL
========================

// Module: column_output_queue
// PURPOSE
//  Drain-side buffer of the systolic array; counterpart to the column input queue. Captures
//  N results per column from the N bottom-edge PEs, stores them row-major (element k of column c
//  at address k*N+c), then streams the N*N results out one word per read request to the host side.
// PARAMETERS
//  N           8   systolic array dimension (columns, and results per column)
//  DATA_WIDTH  32  result word width
// PORTS
//  clk_i            in   1               clock, all logic on rising edge
//  rstn_i           in   1               reset, synchronous, active-low
//  start_i          in   1               begin collecting a new N*N tile
//  data_i[0:N-1]    in   DATA_WIDTH each result from bottom-edge PE of column c
//  valid_i          in   N               per-column result strobe
//  last_i           in   N               per-column end-of-column marker (accompanies Nth valid)
//  read_enable_i    in   1               request next stored word
//  read_reset_i     in   1               rewind read pointer to 0
//  read_data_o      out  DATA_WIDTH      stored word, 1 cycle after accepted request
//  read_valid_o     out  1               read_data_o valid strobe
//  collect_done_o   out  1               all N*N results captured (level)
//  error_o          out  1               sticky protocol error (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (rstn_i low at clk edge): state IDLE; col_count[c]=0, wr_addr[c]=c, rd_addr=0;
//    read_data_o=0, read_valid_o=0, collect_done_o=0, error_o=0. RAM contents not cleared.
//  - FSM: IDLE -start_i-> COLLECT; COLLECT -all col_count==N-> DONE; DONE -start_i-> COLLECT
//    (counts/wr_addr re-init to 0/c, rd_addr=0, collect_done_o drops same edge).
//    start_i in COLLECT ignored.
//  - COLLECT: valid_i[c] with col_count[c]<N -> RAM[wr_addr[c]]<=data_i[c]; wr_addr[c]+=N;
//    col_count[c]++. All N columns may write in the same cycle (N write lanes, disjoint addrs).
//    valid_i[c] with col_count[c]==N: dropped, no write. valid_i outside COLLECT: ignored.
//  - last_i is informational; completion is count-based only.
//  - collect_done_o: registered, high from the cycle after the final capture until next start.
//  - Read (DONE only): read_enable_i && rd_addr<N*N -> read_data_o<=RAM[rd_addr] next cycle,
//    read_valid_o pulses 1 cycle, rd_addr++. rd_addr==N*N: request ignored, read_valid_o low.
//    read_enable_i outside DONE: ignored. read_reset_i has priority over read_enable_i same cycle.
//  - read_data_o holds last value when read_valid_o low.
//  - Widths: col_count $clog2(N+1) bits; addresses $clog2(N*N) bits, rd_addr $clog2(N*N+1).
// CONFIGURATION
//  COLUMN_OUTQ_PROTO_CHECK_EN defined: error_o set (sticky until reset or start_i) on:
//    valid_i[c] when col_count[c]==N; last_i[c] without valid_i[c]; last_i[c] on a valid
//    whose col_count[c]!=N-1; valid_i[c] with col_count[c]==N-1 and !last_i[c].
//  Undefined: no checker logic; error_o tied 0.
// STRUCTURE
//  - systolic_pkg: outq_state_t enum {OUTQ_IDLE, OUTQ_COLLECT, OUTQ_DONE}; localparam helper
//    functions for count/address widths.
//  - Sub-module outq_ram: N write lanes, 1 registered read port, DATA_WIDTH x N*N storage.
//  - Top holds FSM, per-column counters/pointers, read pointer, optional checker.
// TESTING (N=4, DATA_WIDTH=32)
//  - Reset: all outputs 0, 3 read requests in IDLE -> read_valid_o stays 0.
//  - Lockstep: start, then 4 cycles all valid_i=4'hF, data=16*k+c -> collect_done_o high 1 cycle
//    after 4th; 16 reads return 0x00,0x01,0x02,0x03,0x10..0x33 in order, 17th read no valid.
//  - Skewed (systolic wavefront): column c valid on cycles c..c+3 -> identical read stream,
//    done asserted cycle after column 3's last valid.
//  - Over-run: 5th valid on column 0 -> no overwrite of addr 0..15; with
//    COLUMN_OUTQ_PROTO_CHECK_EN error_o=1, without error_o=0.
//  - read_reset_i with read_enable_i after 5 reads -> rd_addr 0, next read returns word 0x00.
//  - Reset mid-COLLECT after 2 captures, then start + full tile -> done after 4 fresh captures.

Source files
------------

// File: rtl/column_output_queue_pkg.sv
// Shared types and width helpers for the systolic array drain path.
package systolic_pkg;

   typedef enum logic [1:0] {
      OUTQ_IDLE,
      OUTQ_COLLECT,
      OUTQ_DONE
   } outq_state_t;

   function automatic int cnt_w(input int n);
      return $clog2(n + 1);
   endfunction

   function automatic int addr_w(input int n);
      return $clog2(n * n);
   endfunction

   function automatic int rptr_w(input int n);
      return $clog2(n * n + 1);
   endfunction

endpackage

// File: rtl/column_output_queue_ram.sv
// Tile storage: N independent write lanes, one registered read port.
module outq_ram
   import systolic_pkg::*;
#(
   parameter int N          = 8,
   parameter int DATA_WIDTH = 32,
   parameter int AW         = addr_w(N)
) (
   input  logic                  clk_i,
   input  logic                  rstn_i,
   input  logic [N-1:0]          we_i,
   input  logic [AW-1:0]         waddr_i [0:N-1],
   input  logic [DATA_WIDTH-1:0] wdata_i [0:N-1],
   input  logic                  re_i,
   input  logic [AW-1:0]         raddr_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   logic [DATA_WIDTH-1:0] mem_q [0:N*N-1];
   logic [DATA_WIDTH-1:0] rdata_q;

   // Lanes never collide: column c only ever writes addresses == c mod N.
   always_ff @(posedge clk_i) begin
      for (int c = 0; c < N; c++) begin
         if (we_i[c]) mem_q[waddr_i[c]] <= wdata_i[c];
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) rdata_q <= '0;
      else if (re_i) rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/column_output_queue.sv
// Drain-side result buffer; optional COLUMN_OUTQ_PROTO_CHECK_EN adds a sticky protocol checker.
module column_output_queue
   import systolic_pkg::*;
#(
   parameter int N          = 8,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk_i,
   input  logic                  rstn_i,
   input  logic                  start_i,
   input  logic [DATA_WIDTH-1:0] data_i [0:N-1],
   input  logic [N-1:0]          valid_i,
   input  logic [N-1:0]          last_i,
   input  logic                  read_enable_i,
   input  logic                  read_reset_i,
   output logic [DATA_WIDTH-1:0] read_data_o,
   output logic                  read_valid_o,
   output logic                  collect_done_o,
   output logic                  error_o
);

   localparam int CW = cnt_w(N);
   localparam int AW = addr_w(N);
   localparam int RW = rptr_w(N);

   outq_state_t   state_q, state_d;
   logic [CW-1:0] cnt_q [N];
   logic [CW-1:0] cnt_d [N];
   logic [AW-1:0] wa_q [N];
   logic [AW-1:0] wa_d [N];
   logic [RW-1:0] rd_q, rd_d;
   logic          rvalid_q, rvalid_d;
   logic          done_q, done_d;
   logic [N-1:0]  we;
   logic          re;
   logic          all_full;
   logic          start_ok;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      wa_d     = wa_q;
      rd_d     = rd_q;
      rvalid_d = 1'b0;
      done_d   = done_q;
      we       = '0;
      re       = 1'b0;
      all_full = 1'b1;
      start_ok = 1'b0;
      unique case (state_q)
         OUTQ_IDLE: begin
            if (start_i) begin
               start_ok = 1'b1;
               state_d  = OUTQ_COLLECT;
            end
         end
         OUTQ_COLLECT: begin
            for (int c = 0; c < N; c++) begin
               if (valid_i[c] && cnt_q[c] != CW'(N)) begin
                  we[c]    = 1'b1;
                  cnt_d[c] = cnt_q[c] + 1'b1;
                  wa_d[c]  = wa_q[c] + AW'(N);
               end
               if (cnt_d[c] != CW'(N)) all_full = 1'b0;
            end
            if (all_full) begin
               state_d = OUTQ_DONE;
               done_d  = 1'b1;
            end
         end
         OUTQ_DONE: begin
            if (start_i) begin
               start_ok = 1'b1;
               state_d  = OUTQ_COLLECT;
               done_d   = 1'b0;
            end else if (read_reset_i) begin
               rd_d = '0;
            end else if (read_enable_i && rd_q < RW'(N * N)) begin
               re       = 1'b1;
               rvalid_d = 1'b1;
               rd_d     = rd_q + 1'b1;
            end
         end
         default: state_d = OUTQ_IDLE;
      endcase
      if (start_ok) begin
         rd_d = '0;
         for (int c = 0; c < N; c++) begin
            cnt_d[c] = '0;
            wa_d[c]  = AW'(c);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         state_q  <= OUTQ_IDLE;
         rd_q     <= '0;
         rvalid_q <= 1'b0;
         done_q   <= 1'b0;
         for (int c = 0; c < N; c++) begin
            cnt_q[c] <= '0;
            wa_q[c]  <= AW'(c);
         end
      end else begin
         state_q  <= state_d;
         rd_q     <= rd_d;
         rvalid_q <= rvalid_d;
         done_q   <= done_d;
         cnt_q    <= cnt_d;
         wa_q     <= wa_d;
      end
   end

   outq_ram #(
      .N          (N),
      .DATA_WIDTH (DATA_WIDTH),
      .AW         (AW)
   ) u_ram (
      .clk_i   (clk_i),
      .rstn_i  (rstn_i),
      .we_i    (we),
      .waddr_i (wa_q),
      .wdata_i (data_i),
      .re_i    (re),
      .raddr_i (rd_q[AW-1:0]),
      .rdata_o (read_data_o)
   );

   assign read_valid_o   = rvalid_q;
   assign collect_done_o = done_q;

`ifdef COLUMN_OUTQ_PROTO_CHECK_EN
   logic err_q, err_d;

   // last_i must accompany exactly the Nth valid of each column.
   always_comb begin
      err_d = err_q;
      if (start_ok) err_d = 1'b0;
      if (state_q == OUTQ_COLLECT) begin
         for (int c = 0; c < N; c++) begin
            if ((valid_i[c] && cnt_q[c] == CW'(N)) ||
                (last_i[c] && !valid_i[c]) ||
                (last_i[c] && valid_i[c] &&
                 cnt_q[c] != CW'(N - 1)) ||
                (valid_i[c] && !last_i[c] &&
                 cnt_q[c] == CW'(N - 1)))
               err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) err_q <= 1'b0;
      else err_q <= err_d;
   end

   assign error_o = err_q;
`else
   logic unused_last;
   assign unused_last = ^last_i;
   assign error_o     = 1'b0;
`endif

endmodule
